ysyx_23060187_ifu: RTL and testbench



---
 rtl/ysyx_23060187_ifu_pkg.sv | 17 +
 rtl/ysyx_23060187_ifu_pc.sv | 34 +++
 rtl/ysyx_23060187_ifu.sv | 130 +++++++++++++
 tb/tb_ysyx_23060187_ifu.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060187_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// reset PC default, instruction width and the canonical NOP word.
package ysyx_23060187_ifu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_HALT = 3'd4
    } ifu_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam int          INST_W           = 32;
    localparam logic [31:0] NOP              = 32'h0000_0013;

endpackage

// File: rtl/ysyx_23060187_ifu_pc.sv
// PC register of the fetch unit: next-PC mux (pc+4 or jump target) and
// the misaligned-target check. The PC only moves on a clean retire; a
// misaligned jump leaves it untouched so the faulting PC stays visible.
module ysyx_23060187_ifu_pc #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h8000_0000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] pc,
    output logic              misalign
);

    logic [ADDR_W-1:0] pc_next;

    // Next-PC selection and alignment check; pc+4 wraps naturally.
    always_comb begin
        misalign = jump && (jump_target[1:0] != 2'b00);
        pc_next  = jump ? jump_target : pc + ADDR_W'(4);
    end

    // PC register, updated only on a retire that is not a misaligned jump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (retire && !misalign) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit top: fetch FSM, memory request channel and the
// instruction handshake toward decode. One request outstanding at most.
// Optional performance counters are built when YSYX_23060187_IFU_PERF_EN
// is defined.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The valid side holds its payload stable until that edge and never
// depends combinationally on ready.
module ysyx_23060187_ifu
    import ysyx_23060187_ifu_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    input  logic              mem_resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              fetch_err,
`ifdef YSYX_23060187_IFU_PERF_EN
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_stall_cnt,
`endif
    output logic [2:0]        dbg_state
);

    ifu_state_t state, state_next;
    logic       retire;
    logic       misalign;
    logic       resp_ok;
    logic       resp_fault;
    logic       jump_fault;

    ysyx_23060187_ifu_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst         (rst),
        .retire      (retire),
        .jump        (jump),
        .jump_target (jump_target),
        .pc          (pc),
        .misalign    (misalign)
    );

    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, handshake outputs and qualified events.
    always_comb begin
        state_next    = state;
        mem_req_valid = 1'b0;
        mem_req_addr  = pc;
        inst_valid    = 1'b0;
        retire        = 1'b0;
        resp_ok       = 1'b0;
        resp_fault    = 1'b0;
        jump_fault    = 1'b0;
        case (state)
            ST_IDLE: state_next = ST_REQ;
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_resp_valid) begin
                    resp_ok    = !mem_resp_err;
                    resp_fault = mem_resp_err;
                    state_next = mem_resp_err ? ST_HALT : ST_HOLD;
                end
            end
            ST_HOLD: begin
                inst_valid = 1'b1;
                if (inst_ready) begin
                    retire     = 1'b1;
                    jump_fault = misalign;
                    state_next = misalign ? ST_HALT : ST_REQ;
                end
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_IDLE;
        endcase
    end

    // Instruction capture on a good response; sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst      <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (resp_ok) inst <= mem_resp_data;
            if (resp_fault || jump_fault) fetch_err <= 1'b1;
        end
    end

`ifdef YSYX_23060187_IFU_PERF_EN
    // Saturating performance counters: good fetches and REQ/WAIT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (resp_ok && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if ((state == ST_REQ || state == ST_WAIT) && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Directed testbench for ysyx_23060187_ifu. Inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
module tb_ysyx_23060187_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready  = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data  = 32'h0;
    logic        mem_resp_err   = 1'b0;
    logic        inst_valid;
    logic        inst_ready     = 1'b0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        jump           = 1'b0;
    logic [31:0] jump_target    = 32'h0;
    logic        fetch_err;
    logic [2:0]  dbg_state;

    int passed = 0;
    int total  = 0;

    localparam logic [63:0] S_IDLE = 64'd0;
    localparam logic [63:0] S_REQ  = 64'd1;
    localparam logic [63:0] S_HALT = 64'd4;

    always #5 clk = ~clk;

    ysyx_23060187_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .pc             (pc),
        .jump           (jump),
        .jump_target    (jump_target),
        .fetch_err      (fetch_err),
        .dbg_state      (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic wait_req(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_req_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // One fetch: accept the request, optionally poke inst_ready/jump while
    // nothing is valid, then return data or an access fault.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input bit err, input bit noise, input logic [31:0] prev_inst);
        bit found;
        wait_req(found);
        check("req_seen", 64'(found), 64'd1);
        check("req_addr", 64'(mem_req_addr), 64'(addr));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("req_drop_in_wait", 64'(mem_req_valid), 64'd0);
        if (noise) begin
            inst_ready  = 1'b1;
            jump        = 1'b1;
            jump_target = 32'h8000_0200;
            @(negedge clk);
            inst_ready  = 1'b0;
            jump        = 1'b0;
            check("noise_no_valid", 64'(inst_valid), 64'd0);
            check("noise_pc_hold", 64'(pc), 64'(addr));
        end
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        mem_resp_err   = err;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        if (err) begin
            check("err_flag", 64'(fetch_err), 64'd1);
            check("err_no_valid", 64'(inst_valid), 64'd0);
            check("err_halt", 64'(dbg_state), S_HALT);
            check("err_inst_kept", 64'(inst), 64'(prev_inst));
        end else begin
            check("inst_valid", 64'(inst_valid), 64'd1);
            check("inst_data", 64'(inst), 64'(data));
            check("inst_pc", 64'(pc), 64'(addr));
            check("no_req_in_hold", 64'(mem_req_valid), 64'd0);
        end
    endtask

    task automatic retire(input bit j, input logic [31:0] tgt);
        inst_ready  = 1'b1;
        jump        = j;
        jump_target = tgt;
        @(negedge clk);
        inst_ready  = 1'b0;
        jump        = 1'b0;
        check("retire_drop_valid", 64'(inst_valid), 64'd0);
    endtask

    initial begin
        bit found;

        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        check("rst_pc", 64'(pc), 64'h8000_0000);
        check("rst_inst", 64'(inst), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_fetch_err", 64'(fetch_err), 64'd0);
        check("rst_state", 64'(dbg_state), S_IDLE);
        rst = 1'b0;
        check("idle_no_req", 64'(mem_req_valid), 64'd0);

        // First fetch, then decode stalls for 10 cycles.
        fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_no_req", 64'(mem_req_valid), 64'd0);
            check("stall_valid", 64'(inst_valid), 64'd1);
        end
        check("stall_pc", 64'(pc), 64'h8000_0000);
        check("stall_inst", 64'(inst), 64'h0000_0013);
        retire(1'b0, 32'h0);
        check("retire_pc4", 64'(pc), 64'h8000_0004);

        // Sequential fetch with inst_ready/jump poked while invalid.
        fetch(32'h8000_0004, 32'h0010_0093, 1'b0, 1'b1, 32'h0);
        retire(1'b0, 32'h0);

        // Access fault at 0x80000008, then a stray response.
        fetch(32'h8000_0008, 32'hdead_beef, 1'b1, 1'b0, 32'h0010_0093);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1111_1111;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("stray_no_valid", 64'(inst_valid), 64'd0);
        check("stray_inst_kept", 64'(inst), 64'h0010_0093);
        check("stray_halt", 64'(dbg_state), S_HALT);
        check("stray_no_req", 64'(mem_req_valid), 64'd0);

        // Reset out of HALT; jumps, wrap of pc+4, then misaligned jump.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_err_clear", 64'(fetch_err), 64'd0);
        check("rst2_pc", 64'(pc), 64'h8000_0000);
        fetch(32'h8000_0000, 32'h0000_0297, 1'b0, 1'b0, 32'h0);
        retire(1'b1, 32'h8000_0100);
        fetch(32'h8000_0100, 32'h0000_006f, 1'b0, 1'b0, 32'h0);
        retire(1'b1, 32'hffff_fffc);
        fetch(32'hffff_fffc, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        retire(1'b0, 32'h0);
        fetch(32'h0000_0000, 32'h0040_0113, 1'b0, 1'b0, 32'h0);
        retire(1'b1, 32'h8000_0102);
        check("mis_err", 64'(fetch_err), 64'd1);
        check("mis_halt", 64'(dbg_state), S_HALT);
        check("mis_pc_kept", 64'(pc), 64'h0000_0000);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("halt_no_req", 64'(mem_req_valid), 64'd0);
        end

        // Reset asserted while a response is pending, late response ignored.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fetch(32'h8000_0000, 32'h0000_0013, 1'b0, 1'b0, 32'h0);
        retire(1'b0, 32'h0);
        wait_req(found);
        check("pre_wait_req", 64'(found), 64'd1);
        check("pre_wait_addr", 64'(mem_req_addr), 64'h8000_0004);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        check("async_state", 64'(dbg_state), S_IDLE);
        check("async_req", 64'(mem_req_valid), 64'd0);
        check("async_pc", 64'(pc), 64'h8000_0000);
        check("async_inst", 64'(inst), 64'd0);
        @(negedge clk);
        rst            = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_err   = 1'b1;
        mem_resp_data  = 32'h2222_2222;
        @(negedge clk);
        check("late_req", 64'(dbg_state), S_REQ);
        check("late_err", 64'(fetch_err), 64'd0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        check("late_err2", 64'(fetch_err), 64'd0);
        check("late_no_valid", 64'(inst_valid), 64'd0);
        check("late_inst", 64'(inst), 64'd0);
        fetch(32'h8000_0000, 32'h0050_0193, 1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
